pulse_stretcher: RTL and testbench

//   Converts a one-cycle trigger pulse into a level held for a programmable

---
 rtl/pulse_stretcher.sv | 128 ++++++++++++
 tb/tb_pulse_stretcher.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Stretches a one-cycle trigger into a level held for HOLD_CYCLES clocks,
// optionally followed by a GAP_CYCLES lockout during which triggers are dropped.
module pulse_stretcher #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 0,
    parameter bit RETRIGGER   = 1'b1,
    localparam int CNT_W      = $clog2(HOLD_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    output logic             out,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic             dropped
);

    // The shared counter must also hold GAP_CYCLES-1, which may exceed the hold length.
    localparam int MAX_CNT = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
    localparam int CTR_W   = $clog2(MAX_CNT + 1);

    localparam logic [CTR_W-1:0] HOLD_LOAD = CTR_W'(HOLD_CYCLES - 1);
    localparam logic [CTR_W-1:0] GAP_LOAD  = CTR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_REM  = CNT_W'(HOLD_CYCLES);

    if (HOLD_CYCLES < 1) begin : g_badHold
        $fatal(1, "pulse_stretcher: HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 0) begin : g_badGap
        $fatal(1, "pulse_stretcher: GAP_CYCLES must be >= 0");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_GAP
    } state_t;

    state_t             r_state;
    logic [CTR_W-1:0]   r_cnt;
    logic               r_out;
    logic               r_busy;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_dropped;

    logic               w_cntZero;
    logic               w_reload;

    assign w_cntZero = (r_cnt == '0);
    // Back-to-back acceptance at the end of a hold with no lockout wins over RETRIGGER=0.
    assign w_reload  = in && ((w_cntZero && (GAP_CYCLES == 0)) || RETRIGGER);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out       <= 1'b0;
            r_busy      <= 1'b0;
            r_remaining <= '0;
            r_dropped   <= 1'b0;
        end else begin
            r_dropped <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in) begin
                        r_state     <= S_HOLD;
                        r_cnt       <= HOLD_LOAD;
                        r_out       <= 1'b1;
                        r_busy      <= 1'b1;
                        r_remaining <= HOLD_REM;
                    end
                end

                S_HOLD: begin
                    if (w_reload) begin
                        r_cnt       <= HOLD_LOAD;
                        r_remaining <= HOLD_REM;
                    end else begin
                        if (in) begin
                            r_dropped <= 1'b1;
                        end
                        if (w_cntZero) begin
                            r_out       <= 1'b0;
                            r_remaining <= '0;
                            if (GAP_CYCLES > 0) begin
                                r_state <= S_GAP;
                                r_cnt   <= GAP_LOAD;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_cnt       <= r_cnt - CTR_W'(1);
                            r_remaining <= r_remaining - CNT_W'(1);
                        end
                    end
                end

                S_GAP: begin
                    if (in) begin
                        r_dropped <= 1'b1;
                    end
                    if (w_cntZero) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CTR_W'(1);
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_out       <= 1'b0;
                    r_busy      <= 1'b0;
                    r_remaining <= '0;
                end
            endcase
        end
    end

    assign out       = r_out;
    assign busy      = r_busy;
    assign remaining = r_remaining;
    assign dropped   = r_dropped;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: four parameterisations share one trigger,
// each scenario compares one instance against hand-computed per-cycle tables.
module tb_pulse_stretcher;

    logic clk;
    logic reset;
    logic trig;

    int checkCount;
    int errorCount;

    logic       outA, busyA, dropA;
    logic [2:0] remA;
    logic       outB, busyB, dropB;
    logic [2:0] remB;
    logic       outC, busyC, dropC;
    logic [2:0] remC;
    logic       outD, busyD, dropD;
    logic [0:0] remD;

    pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1'b1)) dutA (
        .clk(clk), .reset(reset), .in(trig),
        .out(outA), .busy(busyA), .remaining(remA), .dropped(dropA));

    pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1'b0)) dutB (
        .clk(clk), .reset(reset), .in(trig),
        .out(outB), .busy(busyB), .remaining(remB), .dropped(dropB));

    pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .RETRIGGER(1'b0)) dutC (
        .clk(clk), .reset(reset), .in(trig),
        .out(outC), .busy(busyC), .remaining(remC), .dropped(dropC));

    pulse_stretcher #(.HOLD_CYCLES(1), .GAP_CYCLES(2), .RETRIGGER(1'b1)) dutD (
        .clk(clk), .reset(reset), .in(trig),
        .out(outD), .busy(busyD), .remaining(remD), .dropped(dropD));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Leaves the bench at a negedge with reset released; the next posedge is cycle 0.
    task automatic resetDut();
        @(negedge clk);
        trig  = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Cycle k values are sampled at the negedge before posedge k, then in for cycle k is driven.
    task automatic applyStimulus(input string name, input int sel, input logic [15:0] pulses,
                                 input logic [15:0] eOut, input logic [15:0] eBusy,
                                 input logic [15:0] eDrop, input logic [63:0] eRem);
        logic       o, b, d;
        logic [3:0] r;
        resetDut();
        for (int k = 0; k < 16; k++) begin
            case (sel)
                0:       begin o = outA; b = busyA; d = dropA; r = {1'b0, remA}; end
                1:       begin o = outB; b = busyB; d = dropB; r = {1'b0, remB}; end
                2:       begin o = outC; b = busyC; d = dropC; r = {1'b0, remC}; end
                default: begin o = outD; b = busyD; d = dropD; r = {3'b000, remD}; end
            endcase
            checkOutput($sformatf("%s out c%0d", name, k), {31'd0, o}, {31'd0, eOut[k]});
            checkOutput($sformatf("%s busy c%0d", name, k), {31'd0, b}, {31'd0, eBusy[k]});
            checkOutput($sformatf("%s dropped c%0d", name, k), {31'd0, d}, {31'd0, eDrop[k]});
            checkOutput($sformatf("%s remaining c%0d", name, k), {28'd0, r},
                        {28'd0, eRem[4*k +: 4]});
            trig = pulses[k];
            @(posedge clk);
            @(negedge clk);
        end
        trig = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset = 1'b0;
        trig  = 1'b0;

        #2;
        checkOutput("async reset out", {31'd0, outA}, 32'd0);
        checkOutput("async reset busy", {31'd0, busyA}, 32'd0);

        applyStimulus("single", 0, 16'h0001, 16'h001E, 16'h007E, 16'h0000,
                      64'h0000_0000_0001_2340);
        applyStimulus("retrig", 0, 16'h0005, 16'h007E, 16'h01FE, 16'h0000,
                      64'h0000_0000_0123_4340);
        applyStimulus("retrigLast", 0, 16'h0011, 16'h01FE, 16'h07FE, 16'h0000,
                      64'h0000_0001_2341_2340);
        applyStimulus("gapDrop", 0, 16'h00A1, 16'h0F1E, 16'h3F7E, 16'h0040,
                      64'h0000_1234_0001_2340);
        applyStimulus("noRetrig", 1, 16'h0005, 16'h001E, 16'h007E, 16'h0008,
                      64'h0000_0000_0001_2340);
        applyStimulus("noRetrigLast", 1, 16'h0011, 16'h001E, 16'h007E, 16'h0020,
                      64'h0000_0000_0001_2340);
        applyStimulus("backToBack", 2, 16'h0011, 16'h01FE, 16'h01FE, 16'h0000,
                      64'h0000_0001_2341_2340);
        applyStimulus("hold1", 3, 16'h004D, 16'h0082, 16'h038E, 16'h0018,
                      64'h0000_0000_1000_0010);

        // Reset asserted between edges in the middle of a hold.
        resetDut();
        trig = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trig = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("midHold out before reset", {31'd0, outA}, 32'd1);
        checkOutput("midHold remaining before reset", {29'd0, remA}, 32'd2);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("midHold out in reset", {31'd0, outA}, 32'd0);
        checkOutput("midHold busy in reset", {31'd0, busyA}, 32'd0);
        checkOutput("midHold remaining in reset", {29'd0, remA}, 32'd0);
        checkOutput("midHold dutB out in reset", {31'd0, outB}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("postReset out c%0d", k), {31'd0, outA}, 32'd0);
            checkOutput($sformatf("postReset busy c%0d", k), {31'd0, busyA}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
